// File: rtl/nibble_word_rx_pkg.sv
// Shared types and helpers for the nibble_word_rx receive path.
// Holds the two-state FSM encoding and the running-checksum combine
// function used when the checksum nibble is enabled.
package nibble_word_rx_pkg;

  // IDLE: no partial word held. COLLECT: at least one nibble of a frame held.
  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  localparam int NIB_W = 4;

  // Running checksum: XOR of every data nibble seen so far in the frame.
  function automatic logic [NIB_W-1:0] nib_xor(input logic [NIB_W-1:0] prev,
                                               input logic [NIB_W-1:0] c);
    return prev ^ c;
  endfunction

endpackage

// File: rtl/nibble_word_rx_asm.sv
// Purpose: nibble shift register plus index counter for one frame.
// Latency: state updates on the clock edge after acc; asm_word is combinational.
// Backpressure: none here, acc is already qualified by the top's handshake.
// Ports: clk/reset (sync, active-high); acc = nibble accepted this cycle;
//   sync = frame restart; c = nibble; part_word = nibbles held so far;
//   asm_word = part_word with c merged at the current index;
//   last = the next accepted nibble completes the frame.
// CK_NIB=1 appends one checksum slot after the data nibbles; that slot
// is never written into the shift register.
module nibble_shift_asm #(
  parameter int NIBBLES   = 8,
  parameter int MSB_FIRST = 1,
  parameter int CK_NIB    = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   acc,
  input  logic                   sync,
  input  logic [3:0]             c,
  output logic [4*NIBBLES-1:0]   part_word,
  output logic [4*NIBBLES-1:0]   asm_word,
  output logic                   last
);
  import nibble_word_rx_pkg::*;

  localparam int W     = 4 * NIBBLES;
  localparam int FRAME = NIBBLES + CK_NIB;
  localparam int IW    = $clog2(FRAME + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME - 1);

  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  sr_q, sr_d;

  // Merge nibble c into base at position pos. MSB-first shifts in at the
  // bottom so the first nibble migrates to the top after NIBBLES shifts.
  function automatic logic [W-1:0] place(input logic [W-1:0]  base,
                                         input logic [IW-1:0] pos,
                                         input logic [3:0]    nib);
    logic [W-1:0] r;
    r = base;
    if (MSB_FIRST != 0) begin
      r = {base[W-5:0], nib};
    end else begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (pos == IW'(i)) r[4*i +: 4] = nib;
      end
    end
    return r;
  endfunction

  always_comb begin
    last      = (idx_q == LAST_IDX);
    asm_word  = place(sr_q, idx_q, c);
    part_word = sr_q;
    idx_d     = idx_q;
    sr_d      = sr_q;
    if (sync) begin
      // A nibble accepted alongside sync starts the new frame.
      idx_d = acc ? IW'(1) : '0;
      sr_d  = acc ? place('0, '0, c) : '0;
    end else if (acc) begin
      if (last) begin
        idx_d = '0;
        sr_d  = '0;
      end else begin
        idx_d = idx_q + 1'b1;
        sr_d  = asm_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
      sr_q  <= '0;
    end else begin
      idx_q <= idx_d;
      sr_q  <= sr_d;
    end
  end

endmodule

// File: rtl/nibble_word_rx.sv
// Purpose: assemble NIBBLES 4-bit nibbles into one word, valid/ready on both sides.
// Latency: word and word_valid are registered, one cycle after the completing nibble.
// Backpressure: c_ready drops only when the next nibble would complete a word
//   while the held word is valid and not being taken this cycle.
// Ports: clk, reset (sync, active-high); c/c_valid/c_ready nibble input;
//   sync frame restart; word/word_valid/word_ready output; words_done wrapping
//   count of delivered words; err one-cycle checksum-fail pulse.
// Optional: define NIBBLE_WORD_RX_CHECKSUM_EN to expect an XOR checksum nibble
//   after the data nibbles; without it err is tied 0.
// Parameters: NIBBLES 2..16, MSB_FIRST (1: first nibble in top bits), CNT_W.
module nibble_word_rx #(
  parameter int NIBBLES   = 8,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           c,
  input  logic                 c_valid,
  output logic                 c_ready,
  input  logic                 sync,
  output logic [4*NIBBLES-1:0] word,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic [CNT_W-1:0]     words_done,
  output logic                 err
);
  import nibble_word_rx_pkg::*;

  localparam int W = 4 * NIBBLES;
`ifdef NIBBLE_WORD_RX_CHECKSUM_EN
  localparam int CK_NIB = 1;
`else
  localparam int CK_NIB = 0;
`endif

  state_e           state_q, state_d;
  logic [W-1:0]     word_q, word_d;
  logic             word_valid_q, word_valid_d;
  logic [CNT_W-1:0] words_done_q, words_done_d;

  logic             acc, take, complete, load, ck_ok, last;
  logic [W-1:0]     part_word, asm_word, load_val;

  nibble_shift_asm #(
    .NIBBLES  (NIBBLES),
    .MSB_FIRST(MSB_FIRST),
    .CK_NIB   (CK_NIB)
  ) u_asm (
    .clk      (clk),
    .reset    (reset),
    .acc      (acc),
    .sync     (sync),
    .c        (c),
    .part_word(part_word),
    .asm_word (asm_word),
    .last     (last)
  );

  // Stall only the completing nibble, and only if its word would have
  // nowhere to go; a take in the same cycle frees the output register.
  assign c_ready = ~((state_q == COLLECT) & last & word_valid_q & ~word_ready);

  assign acc  = c_valid & c_ready;
  assign take = word_valid_q & word_ready;
  // A nibble arriving with sync is nibble 0 of a new frame, never the last.
  assign complete = acc & last & ~sync;
  assign load     = complete & ck_ok;
  // With a checksum slot the data is already fully held when the final
  // (checksum) nibble arrives; otherwise the final nibble is merged in.
  assign load_val = (CK_NIB != 0) ? part_word : asm_word;

`ifdef NIBBLE_WORD_RX_CHECKSUM_EN
  logic [3:0] ck_q, ck_d;
  logic       err_q, err_d;

  always_comb begin
    ck_d = ck_q;
    if (sync)      ck_d = acc ? c : 4'h0;
    else if (acc)  ck_d = last ? 4'h0 : nib_xor(ck_q, c);
    ck_ok = (ck_q == c);
    err_d = complete & ~ck_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ck_q  <= 4'h0;
      err_q <= 1'b0;
    end else begin
      ck_q  <= ck_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign ck_ok = 1'b1;
  assign err   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc) state_d = COLLECT;
      COLLECT: if ((sync & ~acc) | complete) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    word_d       = load ? load_val : word_q;
    word_valid_d = load | (word_valid_q & ~take);
    words_done_d = words_done_q + CNT_W'(load);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      words_done_q <= '0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      words_done_q <= words_done_d;
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign words_done = words_done_q;

endmodule

// File: tb/tb_nibble_word_rx.sv
// Bench for nibble_word_rx: MSB-first and LSB-first instances share inputs,
// every cycle is compared with a queue-based frame model, plus fixed vectors.
module tb_nibble_word_rx;
  localparam int NIBBLES = 8;
  localparam int W       = 4 * NIBBLES;
  localparam int CNT_W   = 8;
`ifdef NIBBLE_WORD_RX_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int FRAME = NIBBLES + CK;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, c_valid, sync, word_ready;
  logic [3:0]       c;
  logic             c_ready_m, c_ready_l, word_valid_m, word_valid_l, err_m, err_l;
  logic [W-1:0]     word_m, word_l;
  logic [CNT_W-1:0] done_m, done_l;

  nibble_word_rx #(.NIBBLES(NIBBLES), .MSB_FIRST(1), .CNT_W(CNT_W)) dut_m (
    .clk(clk), .reset(reset), .c(c), .c_valid(c_valid), .c_ready(c_ready_m),
    .sync(sync), .word(word_m), .word_valid(word_valid_m), .word_ready(word_ready),
    .words_done(done_m), .err(err_m));

  nibble_word_rx #(.NIBBLES(NIBBLES), .MSB_FIRST(0), .CNT_W(CNT_W)) dut_l (
    .clk(clk), .reset(reset), .c(c), .c_valid(c_valid), .c_ready(c_ready_l),
    .sync(sync), .word(word_l), .word_valid(word_valid_l), .word_ready(word_ready),
    .words_done(done_l), .err(err_l));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the current frame is a queue of nibbles; a word is
  // composed arithmetically once the frame is full.
  logic [3:0]       mq[$];
  logic [W-1:0]     m_word_m, m_word_l;
  logic             m_valid, m_err;
  logic [CNT_W-1:0] m_done;

  function automatic logic model_ready(input logic wr);
    return !((mq.size() == FRAME - 1) && m_valid && !wr);
  endfunction

  task automatic model_step(input logic [3:0] cc, input logic cv, input logic sy,
                            input logic wr, input logic rs);
    logic acc, take, loaded, ok;
    logic [3:0] x;
    if (rs) begin
      mq.delete();
      m_word_m = '0; m_word_l = '0; m_valid = 1'b0; m_err = 1'b0; m_done = '0;
      return;
    end
    acc    = cv && model_ready(wr);
    take   = m_valid && wr;
    loaded = 1'b0;
    m_err  = 1'b0;
    if (sy) mq.delete();
    if (acc) begin
      mq.push_back(cc);
      if (mq.size() == FRAME) begin
        ok = 1'b1;
        if (CK != 0) begin
          x = 4'h0;
          for (int i = 0; i < NIBBLES; i++) x = x ^ mq[i];
          ok = (x == mq[NIBBLES]);
        end
        if (ok) begin
          m_word_m = '0; m_word_l = '0;
          for (int i = 0; i < NIBBLES; i++) begin
            m_word_m = (m_word_m << 4) | W'(mq[i]);
            m_word_l = m_word_l | (W'(mq[i]) << (4 * i));
          end
          m_valid = 1'b1;
          m_done  = m_done + 1'b1;
          loaded  = 1'b1;
        end else begin
          m_err = 1'b1;
        end
        mq.delete();
      end
    end
    if (take && !loaded) m_valid = 1'b0;
  endtask

  // One clock: drive at the falling edge, check c_ready, advance the model,
  // then check registered outputs at the next falling edge.
  task automatic cycle(input logic [3:0] cc, input logic cv, input logic sy,
                       input logic wr, input logic rs, output logic rdy);
    logic er;
    c = cc; c_valid = cv; sync = sy; word_ready = wr; reset = rs;
    #1;
    rdy = c_ready_m;
    er  = model_ready(wr);
    chk("c_ready_m", c_ready_m, er);
    chk("c_ready_l", c_ready_l, er);
    model_step(cc, cv, sy, wr, rs);
    @(negedge clk);
    chk("word_m", word_m, m_word_m);
    chk("word_l", word_l, m_word_l);
    chk("word_valid_m", word_valid_m, m_valid);
    chk("word_valid_l", word_valid_l, m_valid);
    chk("words_done_m", done_m, m_done);
    chk("words_done_l", done_l, m_done);
    chk("err_m", err_m, m_err);
    chk("err_l", err_l, m_err);
  endtask

  // Nibble k of the frame for a word written MSB-first; slot NIBBLES is the checksum.
  function automatic logic [3:0] frame_nib(input logic [W-1:0] v, input int k);
    logic [3:0] x;
    if (k < NIBBLES) return v[4*(NIBBLES-1-k) +: 4];
    x = 4'h0;
    for (int i = 0; i < NIBBLES; i++) x = x ^ v[4*i +: 4];
    return x;
  endfunction

  task automatic send_frame(input logic [W-1:0] v, input int n, input logic wr);
    logic r;
    for (int k = 0; k < n; k++) cycle(frame_nib(v, k), 1'b1, 1'b0, wr, 1'b0, r);
  endtask

  typedef struct {
    logic [3:0]       c;
    logic             cv, sy, wr, rs, ck;
    logic [W-1:0]     em, el;
    logic             ev;
    logic [CNT_W-1:0] ed;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic [3:0] cc, input logic cv, input logic sy,
                              input logic wr, input logic rs, input logic ck,
                              input logic [W-1:0] em, input logic [W-1:0] el,
                              input logic ev, input logic [CNT_W-1:0] ed);
    vec_t v;
    v.c = cc; v.cv = cv; v.sy = sy; v.wr = wr; v.rs = rs; v.ck = ck;
    v.em = em; v.el = el; v.ev = ev; v.ed = ed;
    tbl.push_back(v);
  endfunction

  initial begin
    logic r;
    logic [W-1:0] v;
    c = 4'h0; c_valid = 1'b0; sync = 1'b0; word_ready = 1'b1; reset = 1'b1;
    model_step(4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);

    // Basic assembly 1..8 (plus checksum 8 when enabled), then a drain.
    add(4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, '0, '0, 1'b0, '0);
    for (int i = 1; i <= NIBBLES; i++)
      add(4'(i), 1'b1, 1'b0, 1'b1, 1'b0, (i == NIBBLES) && (CK == 0),
          32'h12345678, 32'h87654321, 1'b1, 8'd1);
    if (CK != 0)
      add(4'h8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h12345678, 32'h87654321, 1'b1, 8'd1);
    add(4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h12345678, 32'h87654321, 1'b0, 8'd1);
    foreach (tbl[k]) begin
      cycle(tbl[k].c, tbl[k].cv, tbl[k].sy, tbl[k].wr, tbl[k].rs, r);
      if (tbl[k].ck) begin
        chk("tbl_word_m", word_m, tbl[k].em);
        chk("tbl_word_l", word_l, tbl[k].el);
        chk("tbl_valid", word_valid_m, tbl[k].ev);
        chk("tbl_done", done_m, tbl[k].ed);
      end
    end

    // Backpressure: A held, B's final nibble stalls until word_ready.
    cycle(4'h0, 1'b0, 1'b0, 1'b0, 1'b1, r);
    send_frame(32'h12345678, FRAME, 1'b0);
    chk("bp_a_word", word_m, 32'h12345678);
    send_frame(32'h87654321, FRAME - 1, 1'b0);
    cycle(frame_nib(32'h87654321, FRAME - 1), 1'b1, 1'b0, 1'b0, 1'b0, r);
    chk("bp_stall_ready", r, 1'b0);
    chk("bp_word_held", word_m, 32'h12345678);
    cycle(frame_nib(32'h87654321, FRAME - 1), 1'b1, 1'b0, 1'b1, 1'b0, r);
    chk("bp_release_ready", r, 1'b1);
    chk("bp_b_word", word_m, 32'h87654321);
    chk("bp_b_valid", word_valid_m, 1'b1);
    chk("bp_done", done_m, 8'd2);
    cycle(4'h0, 1'b0, 1'b0, 1'b1, 1'b0, r);

    // sync mid-frame: nibble 9 arriving with sync starts the frame.
    cycle(4'h0, 1'b0, 1'b0, 1'b1, 1'b1, r);
    send_frame(32'h12300000, 3, 1'b1);
    v = 32'h91234567;
    cycle(frame_nib(v, 0), 1'b1, 1'b1, 1'b1, 1'b0, r);
    for (int k = 1; k < FRAME; k++) cycle(frame_nib(v, k), 1'b1, 1'b0, 1'b1, 1'b0, r);
    chk("sync_word_m", word_m, 32'h91234567);
    chk("sync_word_l", word_l, 32'h76543219);
    chk("sync_done", done_m, 8'd1);

    // Reset mid-frame with a held word.
    send_frame(32'h12345678, FRAME, 1'b0);
    send_frame(32'hCAFEF00D, 5, 1'b0);
    cycle(4'h3, 1'b1, 1'b0, 1'b0, 1'b1, r);
    chk("rst_word", word_m, '0);
    chk("rst_valid", word_valid_m, 1'b0);
    chk("rst_done", done_m, '0);
    chk("rst_err", err_m, 1'b0);
    cycle(4'h3, 1'b1, 1'b0, 1'b0, 1'b1, r);
    chk("rst_ready", r, 1'b1);
    send_frame(32'hABCDEF12, FRAME, 1'b1);
    chk("rst_fresh_word", word_m, 32'hABCDEF12);
    chk("rst_fresh_done", done_m, 8'd1);

`ifdef NIBBLE_WORD_RX_CHECKSUM_EN
    // Bad checksum: err pulse, output register and counter untouched.
    cycle(4'h0, 1'b0, 1'b0, 1'b1, 1'b0, r);
    send_frame(32'h12345678, NIBBLES, 1'b1);
    cycle(4'h0, 1'b1, 1'b0, 1'b1, 1'b0, r);
    chk("ck_err_pulse", err_m, 1'b1);
    chk("ck_err_valid", word_valid_m, 1'b0);
    chk("ck_err_done", done_m, 8'd1);
    cycle(4'h0, 1'b0, 1'b0, 1'b1, 1'b0, r);
    chk("ck_err_clear", err_m, 1'b0);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cycle(4'($urandom_range(0, 15)), $urandom_range(0, 9) < 7,
            $urandom_range(0, 99) < 3, $urandom_range(0, 9) < 6,
            $urandom_range(0, 199) == 0, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_word_rx.md
Name: nibble_word_rx

Overview:
- Receive end of the 4-bit `c` nibble stream produced by `text`-style generators.
- Accepts nibbles under a valid/ready handshake and assembles NIBBLES of them into one word.
- Presents each completed word on a registered output with its own valid/ready handshake.
- Sits between a nibble source and downstream word consumers, such as a loader feeding instruction or data memory.

Parameters:
NIBBLES, 8, nibbles per word; word width W = 4*NIBBLES; legal range 2..16
MSB_FIRST, 1, 1: first nibble lands in word[W-1:W-4]; 0: first nibble lands in word[3:0]
CNT_W, 8, width of the completed-word counter

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
c  in  4  incoming nibble
c_valid  in  1  c holds a nibble to transfer
c_ready  out  1  receiver can take a nibble this cycle
sync  in  1  frame restart: discard any partial word
word  out  W  assembled word
word_valid  out  1  word holds an unconsumed result
word_ready  in  1  consumer takes word this cycle
words_done  out  CNT_W  count of words delivered, wraps
err  out  1  one-cycle checksum-fail pulse; tied 0 without CHECKSUM_EN

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high, ports named clk and reset.
- Reset values (reset wins over everything else): word=0, word_valid=0, words_done=0, err=0, nibble index idx=0, shift register=0, state=IDLE. c_ready=1 in the cycle after reset.
- Transfer rules:
  - Nibble transfer: acc = c_valid & c_ready.
  - Word transfer: take = word_valid & word_ready.
- FSM states:
  - IDLE: idx=0, no partial word held.
  - COLLECT: 0<idx<NIBBLES; the shift register holds idx nibbles.
- Transitions:
  - IDLE→COLLECT on acc.
  - COLLECT→IDLE on acc of the last nibble (idx==NIBBLES-1, or the checksum nibble under CHECKSUM_EN), or on sync.
- c_ready is 0 only when both hold:
  - the next accepted nibble would complete a word;
  - word_valid=1 and word_ready=0 in the same cycle.
  Otherwise c_ready=1. This is combinational from state, word_valid and word_ready, with no path from c_valid.
- Completing acc, latency 1:
  - In the next cycle word holds the assembled value and word_valid=1.
  - words_done increments mod 2^CNT_W in that cycle.
  - idx returns to 0.
- Simultaneous load and drain: if take and a completing acc occur in the same cycle, the new word loads and word_valid stays 1.
- Drain only: take with no load clears word_valid next cycle; word keeps its value.
- Sustained throughput is one nibble per cycle, so one word per NIBBLES cycles, as long as the consumer keeps word_ready high.
- sync:
  - Zeroes idx and the shift register.
  - A nibble accepted in the same cycle becomes nibble 0 (idx→1).
  - Does not touch word, word_valid or words_done.
- Reset mid-word discards the partial word and any held output word.
- Nibble placement:
  - MSB_FIRST=1: each new nibble is shifted in at the LSB, so the first nibble ends up in the top nibble.
  - MSB_FIRST=0: each new nibble is written at bits [4*idx+3:4*idx].

Optional Feature:
NIBBLE_WORD_RX_CHECKSUM_EN
- With the macro:
  - Each frame carries NIBBLES data nibbles followed by one checksum nibble, the XOR of all data nibbles.
  - On checksum acc with a match: the word loads as normal.
  - On a mismatch: word and word_valid are unchanged, words_done does not increment, err=1 for exactly one cycle, state returns to IDLE.
  - c_ready stalling applies to the checksum nibble, not the last data nibble.
- Without the macro: no checksum nibble is expected, and err is constant 0.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=1'b0, COLLECT=1'b1;
  - function nib_xor(prev, c) for the running checksum.
- One natural sub-module, nibble_shift_asm: the shift register plus idx counter. Inputs acc, sync, c; outputs the partial word and a last flag.
- The FSM, output register and handshake logic stay in the top.

Test Plan:
- Basic assembly, NIBBLES=8, MSB_FIRST=1, word_ready=1:
  - Stimulus: feed 1,2,3,4,5,6,7,8 on consecutive cycles.
  - Required: word=32'h12345678 with word_valid=1 one cycle after the 8th acc; words_done=1.
- LSB-first placement, MSB_FIRST=0:
  - Stimulus: same nibble sequence 1..8.
  - Required: word=32'h87654321.
- Backpressure:
  - Stimulus: word_ready=0, send two full words A then B.
  - Required: c_ready=0 while B's 8th nibble is pending; word stays A. After one cycle with word_ready=1, B loads in the next cycle with word_valid held at 1; words_done=2.
- sync mid-frame:
  - Stimulus: send 3 nibbles, pulse sync together with nibble 9, then send 7 more nibbles 1..7.
  - Required: word=32'h91234567.
- Reset mid-frame:
  - Stimulus: assert reset after 5 nibbles, then send 8 fresh nibbles.
  - Required: all outputs 0 during reset; the next word contains only the fresh 8 nibbles.
- CHECKSUM_EN:
  - Stimulus: 1..8 followed by checksum 4'h8.
  - Required: word loads 32'h12345678.
  - Stimulus: the same data followed by checksum 4'h0.
  - Required: err pulses for one cycle; word_valid and words_done are unchanged.
